edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event collector and scheduler. Each of N asynchronous-level inputs gets its own rising-edge detector and a one-deep pending flag. A round-robin arbiter shares a single registered event output, carrying the channel id, among all channels under a valid/ready handshake. The block sits between raw single-bit status lines and a single downstream event consumer, such as an interrupt or trace logger.

---
 rtl/edge_event_arbiter_pkg.sv | 12 +
 rtl/edge_event_arbiter_rr_pick.sv | 31 +++
 rtl/edge_event_arbiter.sv | 94 +++++++++
 tb/tb_edge_event_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and helpers for edge_event_arbiter.
// Holds the channel-count ceiling and the round-robin wrap increment.
package edge_event_arbiter_pkg;

  localparam int EEA_NMAX = 32;

  // Pointer increment that wraps from n-1 back to 0.
  function automatic int rr_next(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports: req_i (N requests), ptr_i (start index); gnt_any_o, gnt_id_o.
module edge_event_arbiter_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           gnt_any_o,
  output logic [IDW-1:0] gnt_id_o
);

  int s;

  // Scan from farthest to nearest so the nearest request at or
  // above the pointer is the last (winning) assignment.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_id_o  = '0;
    s         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      if (req_i[s]) begin
        gnt_any_o = 1'b1;
        gnt_id_o  = IDW'(s);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin output scheduling.
// Ports: clk, resetn, din, out_valid/out_ready/out_id, ovf, ovf_clr.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IDW-1:0] out_id,
  output logic [N-1:0]   ovf,
  input  logic [N-1:0]   ovf_clr
);

  logic [N-1:0]   hist_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   ovf_q, ovf_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   ld_vec;
  logic           free;
  logic           load;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;

  edge_event_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .gnt_any_o (gnt_any),
    .gnt_id_o  (gnt_id)
  );

  assign rise = din & ~hist_q;
  assign free = ~valid_q | out_ready;
  assign load = free & gnt_any;

  always_comb begin
    ld_vec = '0;
    if (load) ld_vec[gnt_id] = 1'b1;
  end

  // A rise on the channel being loaded re-arms it; a rise on a
  // channel already pending and not loaded is lost and flagged.
  always_comb begin
    pend_d = (pend_q & ~ld_vec) | rise;
    ovf_d  = (ovf_q & ~ovf_clr) | (rise & pend_q & ~ld_vec);
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (free) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        id_d  = gnt_id;
        ptr_d = IDW'(rr_next(int'(gnt_id), N));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q  <= '1;
      pend_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      hist_q  <= din;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   din;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_id;
  logic [N-1:0]   ovf;
  logic [N-1:0]   ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovf;
  logic         m_v;
  int           m_id;
  int           m_ptr;

  edge_event_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_prev = '1;
    m_pend = '0;
    m_ovf  = '0;
    m_v    = 1'b0;
    m_id   = 0;
    m_ptr  = 0;
  endtask

  // Compare current outputs, apply inputs, advance model and DUT.
  task automatic step(input logic [N-1:0] d,
                      input logic rdy,
                      input logic [N-1:0] clr);
    int win;
    bit fr;
    logic [N-1:0] np;
    logic [N-1:0] no;
    chk("valid", 32'(out_valid), 32'(m_v));
    chk("id", 32'(out_id), 32'(m_id));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    din       = d;
    out_ready = rdy;
    ovf_clr   = clr;
    fr  = !m_v || rdy;
    win = -1;
    if (fr) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && m_pend[c]) win = c;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit r;
      bit ld;
      r  = d[i] && !m_prev[i];
      ld = (win == i);
      np[i] = r || (m_pend[i] && !ld);
      no[i] = (r && m_pend[i] && !ld) || (m_ovf[i] && !clr[i]);
    end
    if (fr) begin
      m_v = (win >= 0);
      if (win >= 0) begin
        m_id  = win;
        m_ptr = (win + 1) % N;
      end
    end
    m_pend = np;
    m_ovf  = no;
    m_prev = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_rst(input logic [N-1:0] d);
    resetn = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    m_reset();
    din       = d;
    out_ready = 1'b0;
    ovf_clr   = '0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    din       = '1;
    out_ready = 1'b0;
    ovf_clr   = '0;
    resetn    = 1'b1;
    m_reset();
    #2;
    async_rst(4'hF);

    // inputs high through reset release: no events
    for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 4'h0);
    chk("hi_rel_valid", 32'(out_valid), 32'd0);

    // single event on channel 2
    step(4'h0, 1'b1, 4'h0);
    step(4'h4, 1'b1, 4'h0);
    step(4'h4, 1'b1, 4'h0);
    chk("single_v", 32'(out_valid), 32'd1);
    chk("single_id", 32'(out_id), 32'd2);
    step(4'h4, 1'b1, 4'h0);
    chk("single_done", 32'(out_valid), 32'd0);

    // simultaneous rises from ptr=0
    async_rst(4'h0);
    step(4'h0, 1'b1, 4'h0);
    step(4'hF, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) step(4'hF, 1'b1, 4'h0);
    chk("simul_empty", 32'(out_valid), 32'd0);

    // backpressure on channels 1 and 3
    step(4'h0, 1'b0, 4'h0);
    step(4'hA, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(4'hA, 1'b0, 4'h0);
    chk("bp_hold_id", 32'(out_id), 32'd1);
    step(4'hA, 1'b1, 4'h0);
    chk("bp_next_id", 32'(out_id), 32'd3);
    step(4'hA, 1'b1, 4'h0);
    step(4'hA, 1'b1, 4'h0);

    // overflow on channel 0 behind a stalled channel-1 event
    step(4'h0, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h3, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h3, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) step(4'h0, 1'b1, 4'h0);
    step(4'h0, 1'b1, 4'h1);
    chk("ovf_clr", 32'(ovf), 32'd0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h3, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h3, 1'b0, 4'h0);
    step(4'h2, 1'b0, 4'h0);
    step(4'h3, 1'b0, 4'h1);
    step(4'h2, 1'b0, 4'h0);
    chk("ovf_set_wins", 32'(ovf[0]), 32'd1);

    // reset while an event is held
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    async_rst(4'hF);
    for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 4'h0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // rotation: 2 delivered, then 0 and 3 together
    step(4'h0, 1'b1, 4'h0);
    step(4'h4, 1'b1, 4'h0);
    step(4'h0, 1'b1, 4'h0);
    step(4'h0, 1'b1, 4'h0);
    step(4'h9, 1'b1, 4'h0);
    step(4'h0, 1'b1, 4'h0);
    chk("rot_first", 32'(out_id), 32'd3);
    step(4'h0, 1'b1, 4'h0);
    chk("rot_second", 32'(out_id), 32'd0);
    step(4'h0, 1'b1, 4'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rd;
      logic [N-1:0] rc;
      logic rr;
      if (i == 300) async_rst(N'($urandom));
      rd = N'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      step(rd, rr, rc);
    end
    step(4'h0, 1'b1, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
